// File: rtl/periph_bridge_ws.sv
// periph_bridge_ws: bridges the CPU data port to NDEV memory-mapped devices.
// Each device owns one STRIDE-byte window starting at BASE. A control window
// follows the last device window and holds the interrupt registers PEND and
// MASK, plus ERRADDR. Device accesses use a sel/ack handshake, so a device may
// insert wait states. A device that never acks is timed out after TIMEOUT edges.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cpu_req/we/addr/wd            CPU request (sampled in IDLE only)
//   cpu_ready/rd/err              one-cycle completion pulse with data and error flag
//   dev_sel/we/addr/wd            registered device strobes (one-hot select, window offset)
//   dev_rd/ack                    per-device read data (32 bits each) and completion
//   dev_irq                       per-device interrupt requests
//   pr_ip                         registered PEND & MASK to CP0 IP[15:10]
module periph_bridge_ws #(
  parameter int unsigned NDEV     = 6,
  parameter logic [31:0] BASE     = 32'h0000_7F00,
  parameter int unsigned STRIDE   = 16,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [5:0]  IRQ_EDGE = 6'b000001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wd,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_rd,
  output logic                 cpu_err,
  output logic [NDEV-1:0]      dev_sel,
  output logic                 dev_we,
  output logic [31:0]          dev_addr,
  output logic [31:0]          dev_wd,
  input  logic [32*NDEV-1:0]   dev_rd,
  input  logic [NDEV-1:0]      dev_ack,
  input  logic [NDEV-1:0]      dev_irq,
  output logic [5:0]           pr_ip
);

  localparam int unsigned     Shift       = $clog2(STRIDE);
  localparam logic [31:0]     OffMask     = 32'(STRIDE - 1);
  localparam logic [7:0]      TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [NDEV-1:0] EdgeMask    = IRQ_EDGE[NDEV-1:0];
  localparam logic [31:0]     ErrData     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [2:0]        idx_q;
  logic [31:0]       addr_q;
  logic              cpu_ready_q;
  logic [31:0]       cpu_rd_q;
  logic              cpu_err_q;
  logic [NDEV-1:0]   dev_sel_q;
  logic              dev_we_q;
  logic [31:0]       dev_addr_q;
  logic [31:0]       dev_wd_q;
  logic [NDEV-1:0]   pend_q, pend_d;
  logic [NDEV-1:0]   mask_q;
  logic [31:0]       erraddr_q;
  logic [NDEV-1:0]   irq_hist_q;
  logic [5:0]        pr_ip_q;

  // Address decode: window number and offset relative to BASE.
  logic [31:0]     rel, win, off;
  logic            in_range, is_dev, is_ctl;
  logic [NDEV-1:0] sel_onehot;

  assign rel      = cpu_addr - BASE;
  assign win      = rel >> Shift;
  assign off      = rel & OffMask;
  assign in_range = (cpu_addr >= BASE);
  assign is_dev   = in_range && (win < NDEV);
  assign is_ctl   = in_range && (win == NDEV);

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      sel_onehot[i] = (win == 32'(i));
    end
  end

  // Read data slice and ack of the latched device.
  logic [31:0] rd_slice;
  logic        ack_sel;

  always_comb begin
    rd_slice = '0;
    ack_sel  = 1'b0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (idx_q == i[2:0]) begin
        rd_slice = dev_rd[32*i +: 32];
        ack_sel  = dev_ack[i];
      end
    end
  end

  // Control window read mux.
  logic [31:0] ctl_rdata;

  always_comb begin
    ctl_rdata = '0;
    case (off)
      32'h0:   ctl_rdata = 32'(pend_q);
      32'h4:   ctl_rdata = 32'(mask_q);
      32'h8:   ctl_rdata = erraddr_q;
      default: ctl_rdata = '0;
    endcase
  end

  // Pending register: edge channels latch rises and clear on W1C, with a
  // same-edge rise taking precedence; level channels just track dev_irq.
  logic [NDEV-1:0] pend_clr, irq_rise;

  always_comb begin
    pend_clr = '0;
    if (state_q == StIdle && cpu_req && is_ctl && cpu_we && off == 32'h0) begin
      pend_clr = cpu_wd[NDEV-1:0];
    end
    irq_rise = dev_irq & ~irq_hist_q;
    pend_d   = (EdgeMask & (irq_rise | (pend_q & ~pend_clr))) | (~EdgeMask & dev_irq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rd_q    <= '0;
      cpu_err_q   <= 1'b0;
      dev_sel_q   <= '0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wd_q    <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      erraddr_q   <= '0;
      irq_hist_q  <= '0;
      pr_ip_q     <= '0;
    end else begin
      irq_hist_q <= dev_irq;
      pend_q     <= pend_d;
      // Uses the pre-edge PEND/MASK, so pr_ip lags both by one edge.
      pr_ip_q    <= 6'(pend_q & mask_q);

      unique case (state_q)
        StIdle: begin
          if (cpu_req) begin
            if (is_dev) begin
              state_q    <= StAccess;
              cnt_q      <= '0;
              idx_q      <= win[2:0];
              addr_q     <= cpu_addr;
              dev_sel_q  <= sel_onehot;
              dev_we_q   <= cpu_we;
              dev_addr_q <= off;
              dev_wd_q   <= cpu_wd;
            end else if (is_ctl) begin
              state_q     <= StDone;
              cpu_ready_q <= 1'b1;
              cpu_err_q   <= 1'b0;
              if (cpu_we) begin
                cpu_rd_q <= '0;
                if (off == 32'h4) begin
                  mask_q <= cpu_wd[NDEV-1:0];
                end
              end else begin
                cpu_rd_q <= ctl_rdata;
              end
            end else begin
              state_q     <= StDone;
              cpu_ready_q <= 1'b1;
              cpu_err_q   <= 1'b1;
              cpu_rd_q    <= ErrData;
              erraddr_q   <= cpu_addr;
            end
          end
        end

        StAccess: begin
          // An ack on the last allowed edge is checked first, so it beats the timeout.
          if (ack_sel) begin
            state_q     <= StDone;
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b0;
            cpu_rd_q    <= dev_we_q ? 32'h0 : rd_slice;
            dev_sel_q   <= '0;
            dev_we_q    <= 1'b0;
          end else if (cnt_q == TimeoutLast) begin
            state_q     <= StDone;
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b1;
            cpu_rd_q    <= ErrData;
            erraddr_q   <= addr_q;
            dev_sel_q   <= '0;
            dev_we_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StDone: begin
          cpu_ready_q <= 1'b0;
          state_q     <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rd    = cpu_rd_q;
  assign cpu_err   = cpu_err_q;
  assign dev_sel   = dev_sel_q;
  assign dev_we    = dev_we_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wd    = dev_wd_q;
  assign pr_ip     = pr_ip_q;

endmodule

// File: tb/tb_periph_bridge_ws.sv
// Self-checking bench for periph_bridge_ws: requests push expected completions
// into a scoreboard; a monitor pops them when cpu_ready pulses. A small device
// model acks each device after a programmable number of ACCESS edges.
module tb_periph_bridge_ws;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] CTL  = 32'h0000_7F60;

  logic         clk;
  logic         reset;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wd;
  logic         cpu_ready;
  logic [31:0]  cpu_rd;
  logic         cpu_err;
  logic [5:0]   dev_sel;
  logic         dev_we;
  logic [31:0]  dev_addr;
  logic [31:0]  dev_wd;
  logic [191:0] dev_rd;
  logic [5:0]   dev_ack;
  logic [5:0]   dev_irq;
  logic [5:0]   pr_ip;

  periph_bridge_ws #(
    .NDEV    (6),
    .BASE    (32'h0000_7F00),
    .STRIDE  (16),
    .TIMEOUT (15),
    .IRQ_EDGE(6'b000001)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wd   (cpu_wd),
    .cpu_ready(cpu_ready),
    .cpu_rd   (cpu_rd),
    .cpu_err  (cpu_err),
    .dev_sel  (dev_sel),
    .dev_we   (dev_we),
    .dev_addr (dev_addr),
    .dev_wd   (dev_wd),
    .dev_rd   (dev_rd),
    .dev_ack  (dev_ack),
    .dev_irq  (dev_irq),
    .pr_ip    (pr_ip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Device model: ack_at[i] = ACCESS edge (1-based) at which device i acks, 0 = never.
  logic [31:0] dev_data [6];
  int          ack_at   [6];
  int          wcnt     [6];
  logic [5:0]  stray_ack;

  always_comb begin
    dev_rd = '0;
    for (int i = 0; i < 6; i++) dev_rd[32*i +: 32] = dev_data[i];
  end

  initial dev_ack = '0;

  always @(negedge clk) begin
    logic [5:0] a;
    a = '0;
    for (int i = 0; i < 6; i++) begin
      if (dev_sel[i] === 1'b1) begin
        a[i] = (ack_at[i] != 0) && (wcnt[i] + 1 == ack_at[i]);
        wcnt[i]++;
      end else begin
        wcnt[i] = 0;
      end
    end
    dev_ack = a | stray_ack;
  end

  // Scoreboard.
  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    int          due;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] exp_sel;
  logic [31:0] exp_addr, exp_wd;
  logic       exp_we;

  always @(negedge clk) begin
    exp_t e;
    if (cpu_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_ready", 32'(cpu_ready), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("cpu_err", 32'(cpu_err), 32'(e.err));
        if (e.chk_rd) check_eq("cpu_rd", cpu_rd, e.rd);
        check_eq("latency", 32'(cyc), 32'(e.due));
      end
    end
    if (dev_sel !== 6'b0 && !reset) begin
      check_eq("dev_sel", 32'(dev_sel), 32'(exp_sel));
      check_eq("dev_addr", dev_addr, exp_addr);
      check_eq("dev_we", 32'(dev_we), 32'(exp_we));
      check_eq("dev_wd", dev_wd, exp_wd);
    end else if (!reset) begin
      check_eq("dev_we_idle", 32'(dev_we), 32'd0);
    end
  end

  // Call right after a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd,
                        input int lat);
    exp_t e;
    int   n;
    if (addr >= BASE && addr < BASE + 32'h60) begin
      exp_sel  = 6'd1 << ((addr - BASE) >> 4);
      exp_addr = addr & 32'hF;
      exp_we   = we;
      exp_wd   = wd;
    end else begin
      exp_sel = '0;
    end
    e.rd = exp_rd; e.err = exp_err; e.chk_rd = chk_rd; e.due = cyc + lat;
    sb.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("done_wait", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
    dev_irq = '0; stray_ack = '0;
    exp_sel = '0; exp_addr = '0; exp_wd = '0; exp_we = 0;
    for (int i = 0; i < 6; i++) begin
      dev_data[i] = 32'hD0D0_0000 | 32'(i);
      ack_at[i]   = 1;
      wcnt[i]     = 0;
    end
    dev_data[1] = 32'hCAFE_0001;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(cpu_ready), 32'd0);
    check_eq("rst_rd", cpu_rd, 32'd0);
    check_eq("rst_err", 32'(cpu_err), 32'd0);
    check_eq("rst_sel", 32'(dev_sel), 32'd0);
    check_eq("rst_daddr", dev_addr, 32'd0);
    check_eq("rst_dwd", dev_wd, 32'd0);
    check_eq("rst_ip", 32'(pr_ip), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Wait-state read, zero-wait write.
    ack_at[1] = 3;
    do_req(1'b0, 32'h7F14, 32'h0, 32'hCAFE_0001, 1'b0, 1'b1, 4);
    ack_at[0] = 1;
    do_req(1'b1, 32'h7F00, 32'h1234, 32'h0, 1'b0, 1'b1, 2);

    // Timeout with acks from other devices, then ERRADDR, then ack on the last edge.
    ack_at[2] = 0;
    stray_ack = 6'b111011;
    do_req(1'b0, 32'h7F24, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 16);
    stray_ack = '0;
    do_req(1'b0, CTL + 32'h8, 32'h0, 32'h7F24, 1'b0, 1'b1, 1);
    ack_at[2] = 15;
    do_req(1'b0, 32'h7F24, 32'h0, dev_data[2], 1'b0, 1'b1, 16);

    // Unmapped and window boundaries.
    do_req(1'b0, 32'h8000, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);
    do_req(1'b0, CTL + 32'h8, 32'h0, 32'h8000, 1'b0, 1'b1, 1);
    do_req(1'b0, 32'h7EFC, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);
    do_req(1'b0, 32'h7F70, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);
    ack_at[5] = 1;
    do_req(1'b0, 32'h7F5F, 32'h0, dev_data[5], 1'b0, 1'b1, 2);
    do_req(1'b1, CTL + 32'hC, 32'h5, 32'h0, 1'b0, 1'b0, 1);
    do_req(1'b0, CTL + 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1);

    // Interrupts.
    do_req(1'b1, CTL + 32'h4, 32'h3F, 32'h0, 1'b0, 1'b0, 1);
    do_req(1'b0, CTL + 32'h4, 32'h0, 32'h3F, 1'b0, 1'b1, 1);
    dev_irq[0] = 1'b1;
    @(negedge clk);
    dev_irq[0] = 1'b0;
    check_eq("ip0_lag", 32'(pr_ip[0]), 32'd0);
    @(negedge clk);
    check_eq("ip0_set", 32'(pr_ip[0]), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("ip0_hold", 32'(pr_ip[0]), 32'd1);
    do_req(1'b0, CTL, 32'h0, 32'h1, 1'b0, 1'b1, 1);
    do_req(1'b1, CTL, 32'h1, 32'h0, 1'b0, 1'b0, 1);
    do_req(1'b0, CTL, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    dev_irq[0] = 1'b1;
    do_req(1'b1, CTL, 32'h1, 32'h0, 1'b0, 1'b0, 1);
    dev_irq[0] = 1'b0;
    do_req(1'b0, CTL, 32'h0, 32'h1, 1'b0, 1'b1, 1);
    dev_irq[1] = 1'b1;
    @(negedge clk);
    check_eq("ip1_rise_lag", 32'(pr_ip[1]), 32'd0);
    @(negedge clk);
    check_eq("ip1_high", 32'(pr_ip[1]), 32'd1);
    dev_irq[1] = 1'b0;
    @(negedge clk);
    check_eq("ip1_fall_lag", 32'(pr_ip[1]), 32'd1);
    @(negedge clk);
    check_eq("ip1_low", 32'(pr_ip[1]), 32'd0);
    check_eq("ip0_before_rst", 32'(pr_ip[0]), 32'd1);

    // Reset in the middle of a wait-state access.
    ack_at[0] = 0;
    exp_sel = 6'b000001; exp_addr = 32'h8; exp_we = 1'b0; exp_wd = 32'h0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7F08; cpu_wd = 32'h0;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_sel", 32'(dev_sel), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_abort_sel", 32'(dev_sel), 32'd0);
    check_eq("rst_abort_ip", 32'(pr_ip), 32'd0);
    check_eq("rst_abort_rdy", 32'(cpu_ready), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    do_req(1'b0, CTL + 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    do_req(1'b0, CTL, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    check_eq("post_rst_ip", 32'(pr_ip), 32'd0);
    ack_at[0] = 2;
    do_req(1'b0, 32'h7F08, 32'h0, dev_data[0], 1'b0, 1'b1, 3);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/periph_bridge_ws.md
Name: periph_bridge_ws

Overview:
Parametrised peripheral bridge between the CPU data port and up to 6 memory-mapped devices.
- Decodes a uniform-stride address map.
- Sequences each access with a request/acknowledge handshake, so devices can insert wait states.
- Times out unresponsive devices and flags unmapped accesses.
- Owns the interrupt pending and mask registers that drive the CP0 hardware interrupt lines.

Parameters:
NDEV, 6, number of device windows (1..6).
BASE, 32'h0000_7F00, byte address of device window 0.
STRIDE, 16, bytes per window; power of two, at least 16.
TIMEOUT, 15, maximum number of ACCESS-state edges without dev_ack before the access errors (1..255).
IRQ_EDGE, 6'b000001, per-channel interrupt mode: 1 = rising-edge latched, 0 = level.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cpu_req  in  1  access request; sampled only in IDLE
cpu_we  in  1  write enable for the request
cpu_addr  in  32  byte address
cpu_wd  in  32  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rd  out  32  read data; valid while cpu_ready is high, held otherwise
cpu_err  out  1  error qualifier; valid while cpu_ready is high
dev_sel  out  NDEV  one-hot device select
dev_we  out  1  device write strobe
dev_addr  out  32  byte offset within the selected window
dev_wd  out  32  device write data
dev_rd  in  32*NDEV  read data; device i occupies bits [32i+31:32i]
dev_ack  in  NDEV  device completion
dev_irq  in  NDEV  device interrupt requests
pr_ip  out  6  IP[15:10] to CP0; bits at index NDEV and above are tied to 0

Behaviour:
Reset:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; PEND=0, MASK=0, ERRADDR=0; irq history=0.
- A reset asserted mid-access aborts the access. No cpu_ready is produced, and dev_sel drops at the reset edge.

Address map:
- Device i window: BASE+i*STRIDE .. BASE+(i+1)*STRIDE-1.
- Control window: BASE+NDEV*STRIDE, size STRIDE.
  - offset 0: PEND; read returns PEND; write is 1-to-clear, affecting edge channels only.
  - offset 4: MASK; read/write, bits [NDEV-1:0].
  - offset 8: ERRADDR; read-only.
  - Other offsets read 0 and ignore writes; they do not error.
- Any address outside all windows is unmapped.

FSM (states IDLE, ACCESS, DONE):
- IDLE, cpu_req=1 at edge t:
  - Device window: latch sel, we, offset and wd; go to ACCESS. dev_sel, dev_we, dev_addr and dev_wd are stable from edge t until ACCESS exits.
  - Control window: perform the register read or write at edge t; go to DONE.
  - Unmapped: go to DONE with err=1 and rd=32'hFFFF_FFFF. ERRADDR<=cpu_addr.
- ACCESS:
  - A 4-bit or wider counter is cleared on entry.
  - dev_ack[sel]=1 at an edge: capture the dev_rd slice (0 for writes); go to DONE with err=0.
  - Otherwise the counter increments. If no ack has arrived at the TIMEOUT-th ACCESS edge, go to DONE with err=1, rd=32'hFFFF_FFFF and ERRADDR<=latched address.
  - Ack at exactly the TIMEOUT-th edge wins over timeout.
  - Acks from unselected devices are ignored.
- DONE: cpu_ready=1 for exactly one cycle, then return to IDLE. cpu_req is ignored while in DONE.
- Latency:
  - Zero-wait-state device: cpu_ready appears 2 edges after request sampling.
  - Control window and unmapped accesses: 1 edge.
- Back-to-back requests start no earlier than the first IDLE cycle after DONE.
- dev_we is asserted only during ACCESS of a write.

Interrupts:
- Level channel: PEND[i]<=dev_irq[i] every edge.
- Edge channel: PEND[i] is set on a 0->1 transition of dev_irq[i] against the registered history. It holds until cleared by a PEND write with bit i=1. If set and clear occur at the same edge, set wins.
- pr_ip<=PEND&MASK, registered. A write to MASK is therefore visible on pr_ip one edge later.

Widths: offset = cpu_addr - window base, truncated to log2(STRIDE) bits and zero-extended to 32 bits.

Test Plan:
1. Read 0x7F14 (device 1, offset 4) with dev_ack[1] delayed 3 edges, dev_rd slice=32'hCAFE0001 -> dev_sel=6'b000010, dev_addr=4, then one cpu_ready pulse with cpu_rd=32'hCAFE0001 and cpu_err=0, 4 edges after sampling.
2. Write 0x7F00 data 32'h1234 with immediate ack -> dev_we=1 and dev_wd=32'h1234 for 1 cycle, cpu_ready after 2 edges, cpu_err=0.
3. Read 0x7F24 (device 2) with no ack, TIMEOUT=15 -> cpu_ready with cpu_err=1 and cpu_rd=32'hFFFFFFFF after 16 edges; reading 0x7F68 (ERRADDR) returns 32'h7F24. Repeat with ack at the 15th ACCESS edge -> err=0.
4. Read 0x8000 (unmapped) -> cpu_ready after 1 edge, cpu_rd=32'hFFFFFFFF, cpu_err=1, dev_sel stays 0.
5. MASK=6'h3F. Pulse dev_irq[0] (edge channel) for 1 cycle -> PEND[0]=1, and pr_ip[0]=1 one edge later, persisting. Write PEND=1 on the same edge dev_irq[0] rises again -> PEND[0] stays 1. Level dev_irq[1] high then low -> pr_ip[1] follows, delayed 2 edges.
6. Assert reset during ACCESS (wait-state device) -> no cpu_ready, dev_sel=0 at the next edge; PEND, MASK and pr_ip are all 0; a subsequent read to device 0 completes normally.
